cfa_mosaic: RTL and testbench
=============================

# cfa_mosaic

Re-mosaicing block for the CFA pipeline. It accepts a full-RGB pixel stream, one pixel per beat in raster order, and emits a single-channel Bayer CFA stream with the same frame geometry. It is used to build Bayer test frames for the demosaic path and for loop-back checks of the green/red/blue reconstruction stages. Both sides use valid/ready handshakes; the output carries start-of-frame, end-of-line and end-of-frame flags.

## Interface
- pixelBitWidth, 12, bits per colour sample
- weightBitWidth, 8, gain width; unsigned Q1.7, so 128 = 1.0
- imgWidth, 640, pixels per line (even, ≥ 2)
- imgHeight, 480, lines per frame (even, ≥ 2)

- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that arms a frame; honoured only in IDLE
- pattern  input  2  Bayer phase, latched on an accepted start: 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
- r_gain, b_gain  input  weightBitWidth  inverse white-balance gains (used only with CFA_MOSAIC_WB_EN)
- red, green, blue  input  pixelBitWidth  input pixel
- in_valid  input  1  input beat valid
- in_ready  output  1  block accepts the input beat
- cfa_pixel  output  pixelBitWidth  mosaiced sample
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts the output beat
- out_sof, out_eol, out_eof  output  1  flags for first pixel of frame, last pixel of line, last pixel of frame
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse after the end-of-frame beat is accepted downstream

## Operation
- States and transitions:
  - IDLE → ACTIVE on start. On that transition: latch pattern, and also latch r_gain/b_gain when CFA_MOSAIC_WB_EN is defined. Clear col and row.
  - ACTIVE → DRAIN when the last input beat is accepted (col = imgWidth-1, row = imgHeight-1).
  - DRAIN → DONE when the out_eof beat is accepted (out_valid & out_ready).
  - DONE → IDLE unconditionally. done = 1 only while in DONE.
- in_ready = (state == ACTIVE) & (!out_valid | out_ready). The input is accepted when in_valid & in_ready.
- Counters:
  - col increments on each accepted input beat and wraps to 0 at imgWidth-1.
  - row increments on that wrap.
  - Neither counter changes on any other beat.
- Colour select: phase = {row[0], col[0]}.
  - RGGB: 00=R, 01=G, 10=G, 11=B
  - GRBG: 00=G, 01=R, 10=B, 11=G
  - GBRG: 00=G, 01=B, 10=R, 11=G
  - BGGR: 00=B, 01=G, 10=G, 11=R
- Flags are computed from the counters at acceptance:
  - out_sof when col = 0 and row = 0
  - out_eol when col = imgWidth-1
  - out_eof when col = imgWidth-1 and row = imgHeight-1
- start while not in IDLE is ignored, including a start in the DONE cycle.
- pattern and gain changes during a frame have no effect on that frame.
- Reset while a frame is in progress: state goes to IDLE, counters clear, and any pending output beat is dropped.

## Timing
- Reset values: in_ready=0, out_valid=0, cfa_pixel=0, out_sof=0, out_eol=0, out_eof=0, busy=0, done=0.
- Latency is one cycle: a beat accepted at edge N appears registered on cfa_pixel/out_valid after edge N.
- Output register behaviour:
  - The output register holds its data and flags while out_valid & !out_ready.
  - out_valid clears when the beat is accepted and no new input beat is accepted on the same edge.
  - With out_ready held at 1, throughput is one pixel per cycle.
- done rises on the edge after the out_eof handshake and lasts exactly one cycle.
- busy rises on the edge after start. The earliest next start is honoured one cycle after done.

## Configuration
- CFA_MOSAIC_WB_EN is defined:
  - R samples become min((red × r_gain) >> 7, 2^pixelBitWidth - 1).
  - B samples become min((blue × b_gain) >> 7, 2^pixelBitWidth - 1).
  - The product is pixelBitWidth + weightBitWidth bits wide; truncate after the shift, then saturate.
  - G samples pass through unscaled.
- CFA_MOSAIC_WB_EN is not defined: the selected channel passes through unmodified, and r_gain/b_gain are unused.
- Latency is one cycle in both builds.

## Test plan
- imgWidth=4, imgHeight=2, pattern=0, out_ready=1, pixels {R,G,B} = {100+i, 200+i, 300+i}:
  - cfa_pixel sequence is 100, 201, 102, 203, 204, 305, 206, 307.
  - sof on beat 0, eol on beats 3 and 7, eof on beat 7.
  - done pulses once, 2 cycles after the last input beat.
- Same frame with pattern=3: sequence is 300, 201, 302, 203, 204, 105, 206, 107.
- Backpressure: out_ready=0 for 3 cycles mid-frame:
  - in_ready=0 and cfa_pixel stays stable.
  - No beat is lost or duplicated; the sequence is identical to the first case.
- start pulsed during ACTIVE with pattern=2: ignored, and the frame completes with the original pattern.
- rst asserted after 5 accepted beats, then a new start:
  - All outputs return to their reset values.
  - The new frame begins with out_sof and col = row = 0.
- With CFA_MOSAIC_WB_EN defined, r_gain=192, b_gain=64:
  - red=4000 gives 4095 (saturated).
  - blue=4000 gives 2000.
  - green=4000 gives 4000.

Source files
------------

// File: rtl/cfa_mosaic.sv
// Re-mosaics a raster RGB stream into a single-channel Bayer CFA stream; optional white-balance gains under CFA_MOSAIC_WB_EN.
// Latency: one cycle from input acceptance to registered output.
// Backpressure: in_ready drops while the output register holds an unaccepted beat.
module cfa_mosaic #(
    parameter int pixelBitWidth  = 12,
    parameter int weightBitWidth = 8,
    parameter int imgWidth       = 640,
    parameter int imgHeight      = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                pattern,
    input  logic [weightBitWidth-1:0] r_gain,
    input  logic [weightBitWidth-1:0] b_gain,
    input  logic [pixelBitWidth-1:0]  red,
    input  logic [pixelBitWidth-1:0]  green,
    input  logic [pixelBitWidth-1:0]  blue,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [pixelBitWidth-1:0]  cfa_pixel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof,
    output logic                      busy,
    output logic                      done
);

    localparam int CW = (imgWidth > 1) ? $clog2(imgWidth) : 1;
    localparam int RW = (imgHeight > 1) ? $clog2(imgHeight) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(imgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(imgHeight - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [CW-1:0]            col_q;
    logic [RW-1:0]            row_q;
    logic [1:0]               pattern_q;
    logic                     arm;
    logic                     accept;
    logic                     col_last;
    logic                     row_last;
    logic [1:0]               site;
    logic [pixelBitWidth-1:0] r_val;
    logic [pixelBitWidth-1:0] b_val;
    logic [pixelBitWidth-1:0] sel_pix;

    assign arm      = (state_q == S_IDLE) & start;
    assign in_ready = (state_q == S_ACTIVE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

`ifdef CFA_MOSAIC_WB_EN
    localparam int PW   = pixelBitWidth + weightBitWidth;
    localparam int FRAC = weightBitWidth - 1;
    localparam logic [PW-1:0] PIX_MAX = PW'({pixelBitWidth{1'b1}});

    logic [weightBitWidth-1:0] r_gain_q;
    logic [weightBitWidth-1:0] b_gain_q;
    logic [PW-1:0]             r_scaled;
    logic [PW-1:0]             b_scaled;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain_q <= '0;
            b_gain_q <= '0;
        end else if (arm) begin
            r_gain_q <= r_gain;
            b_gain_q <= b_gain;
        end
    end

    // Gains are Q1.7-style: drop the fraction bits, then clamp to the sample range.
    assign r_scaled = (PW'(red) * PW'(r_gain_q)) >> FRAC;
    assign b_scaled = (PW'(blue) * PW'(b_gain_q)) >> FRAC;
    assign r_val    = (r_scaled > PIX_MAX) ? {pixelBitWidth{1'b1}} : r_scaled[pixelBitWidth-1:0];
    assign b_val    = (b_scaled > PIX_MAX) ? {pixelBitWidth{1'b1}} : b_scaled[pixelBitWidth-1:0];
`else
    logic unused_gain;
    assign unused_gain = ^{r_gain, b_gain};
    assign r_val       = red;
    assign b_val       = blue;
`endif

    // XOR with the phase code maps every Bayer variant onto RGGB: 00 is red, 11 is blue.
    assign site = {row_q[0], col_q[0]} ^ pattern_q;

    always_comb begin
        sel_pix = green;
        case (site)
            2'b00:   sel_pix = r_val;
            2'b11:   sel_pix = b_val;
            default: sel_pix = green;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACTIVE;
            S_ACTIVE: if (accept & col_last & row_last) state_d = S_DRAIN;
            S_DRAIN:  if (out_valid & out_ready & out_eof) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            pattern_q <= '0;
        end else if (arm) begin
            col_q     <= '0;
            row_q     <= '0;
            pattern_q <= pattern;
        end else if (accept) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Output register: loads on acceptance, otherwise holds until drained downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            cfa_pixel <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            cfa_pixel <= sel_pix;
            out_sof   <= (col_q == '0) & (row_q == '0);
            out_eol   <= col_last;
            out_eof   <= col_last & row_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cfa_mosaic.sv
// Self-checking bench for cfa_mosaic on a 4x2 frame: literal sequences plus a
// Bayer-lookup reference model driven by randomized pixels and handshakes.
module tb_cfa_mosaic;

    localparam int P    = 12;
    localparam int WW   = 8;
    localparam int IW   = 4;
    localparam int IH   = 2;
    localparam int NPIX = IW * IH;
`ifdef CFA_MOSAIC_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pattern = 2'd0;
    logic [WW-1:0] r_gain = 8'd128;
    logic [WW-1:0] b_gain = 8'd128;
    logic [P-1:0]  red = '0;
    logic [P-1:0]  green = '0;
    logic [P-1:0]  blue = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [P-1:0]  cfa_pixel;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int pix;
        int flags;
    } exp_t;

    exp_t expq[$];
    int   got[$];
    int   seq_rggb[NPIX] = '{100, 201, 102, 203, 204, 305, 206, 307};
    int   seq_bggr[NPIX] = '{300, 201, 302, 203, 204, 105, 206, 107};

    always #5 clk = ~clk;

    cfa_mosaic #(
        .pixelBitWidth (P),
        .weightBitWidth(WW),
        .imgWidth      (IW),
        .imgHeight     (IH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .r_gain   (r_gain),
        .b_gain   (b_gain),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfa_pixel(cfa_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .busy     (busy),
        .done     (done)
    );

    // Reference: pick the channel named by the Bayer layout string at (row%2, col%2).
    function automatic int model_pix(int pat, int c, int r, int rv, int gv, int bv, int rg, int bg);
        string s;
        byte   ch;
        int    v;
        case (pat)
            0:       s = "RGGB";
            1:       s = "GRBG";
            2:       s = "GBRG";
            default: s = "BGGR";
        endcase
        ch = s[(r % 2) * 2 + (c % 2)];
        if (ch == "R")      v = WB_EN ? (rv * rg) / 128 : rv;
        else if (ch == "B") v = WB_EN ? (bv * bg) / 128 : bv;
        else                v = gv;
        if (v > 4095) v = 4095;
        return v;
    endfunction

    // mode: 0 ready always, 1 ready low for 3 cycles mid-frame, 2 random handshakes.
    // dmode: 0 sequential pixels, 1 random, 2 constant 4000. inj=1 pulses start mid-frame.
    task automatic run_frame(input int pat, input int mode, input int dmode, input int inj,
                             input int rg, input int bg);
        int   mcol, mrow, acc, outs, last_acc, held_pix;
        bit   held_v, fin;
        exp_t e;
        expq.delete();
        got.delete();
        mcol = 0; mrow = 0; acc = 0; outs = 0; last_acc = 0; held_pix = 0;
        held_v = 1'b0; fin = 1'b0;
        @(negedge clk);
        pattern = 2'(pat);
        r_gain  = WW'(rg);
        b_gain  = WW'(bg);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        pattern = 2'($urandom_range(0, 3));
        r_gain  = WW'($urandom);
        b_gain  = WW'($urandom);
        #1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int k = 0; k < 300 && !fin; k++) begin
            if (acc < NPIX) in_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            else            in_valid = 1'b0;
            case (dmode)
                0: begin red = P'(100 + acc); green = P'(200 + acc); blue = P'(300 + acc); end
                1: begin red = P'($urandom); green = P'($urandom); blue = P'($urandom); end
                default: begin red = 12'd4000; green = 12'd4000; blue = 12'd4000; end
            endcase
            if (mode == 0)      out_ready = 1'b1;
            else if (mode == 1) out_ready = !(k >= 4 && k <= 6);
            else                out_ready = ($urandom_range(0, 2) != 0);
            start = (inj == 1 && k == 3);
            if (inj == 1 && k == 3) pattern = 2'd2;
            #1;
            if (held_v) begin
                n_tests++;
                if (cfa_pixel !== P'(held_pix) || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold: got pix=%0d vld=%b expected pix=%0d vld=1",
                             cfa_pixel, out_valid, held_pix);
                end
            end
            if (out_valid && !out_ready) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
            end
            held_v   = out_valid && !out_ready;
            held_pix = int'(cfa_pixel);
            if (out_valid && out_ready) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got pix=%0d expected no beat", cfa_pixel);
                end else begin
                    e = expq.pop_front();
                    if (int'(cfa_pixel) != e.pix) begin
                        n_fail++;
                        $display("FAIL pixel[%0d]: got %0d expected %0d", outs, cfa_pixel, e.pix);
                    end
                    n_tests++;
                    if (int'({out_sof, out_eol, out_eof}) != e.flags) begin
                        n_fail++;
                        $display("FAIL flags[%0d]: got sof/eol/eof=%03b expected %03b",
                                 outs, {out_sof, out_eol, out_eof}, 3'(e.flags));
                    end
                end
                got.push_back(int'(cfa_pixel));
                outs++;
            end
            if (in_valid && in_ready) begin
                e.pix   = model_pix(pat, mcol, mrow, int'(red), int'(green), int'(blue), rg, bg);
                e.flags = ((mcol == 0 && mrow == 0) ? 4 : 0) + ((mcol == IW - 1) ? 2 : 0)
                        + ((mcol == IW - 1 && mrow == IH - 1) ? 1 : 0);
                expq.push_back(e);
                acc++;
                last_acc = k;
                mcol++;
                if (mcol == IW) begin
                    mcol = 0;
                    mrow++;
                end
            end
            if (done === 1'b1) begin
                fin = 1'b1;
                if (mode != 2) begin
                    n_tests++;
                    if (k != last_acc + 2) begin
                        n_fail++;
                        $display("FAIL done_timing: got cycle %0d expected %0d", k, last_acc + 2);
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_timeout: got no done expected done within 300 cycles");
        end
        n_tests++;
        if (outs != NPIX || expq.size() != 0) begin
            n_fail++;
            $display("FAIL beat_count: got %0d beats (%0d pending) expected %0d",
                     outs, expq.size(), NPIX);
        end
        // A start presented during the DONE cycle must be ignored.
        start   = 1'b1;
        pattern = 2'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b0;
        #1;
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_sof, out_eol, out_eof, busy, done} !== 7'b0 || cfa_pixel !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy/vld/sof/eol/eof/busy/done=%07b pix=%0d expected all 0",
                     {in_ready, out_valid, out_sof, out_eol, out_eof, busy, done}, cfa_pixel);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b in_ready=%b expected 0 0", busy, in_ready);
        end
    endtask

    task automatic test_seq(input string name, input int pat, input int mode, input int inj,
                            input int ref_seq[NPIX]);
        run_frame(pat, mode, 0, inj, 128, 128);
        for (int i = 0; i < NPIX; i++) begin
            n_tests++;
            if (i >= got.size() || got[i] != ref_seq[i]) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %0d expected %0d", name, i,
                         (i < got.size()) ? got[i] : -1, ref_seq[i]);
            end
        end
    endtask

    task automatic test_basic();
        test_seq("basic_rggb", 0, 0, 0, seq_rggb);
    endtask

    task automatic test_pattern3();
        test_seq("bggr", 3, 0, 0, seq_bggr);
    endtask

    task automatic test_backpressure();
        test_seq("backpressure", 0, 1, 0, seq_rggb);
    endtask

    task automatic test_start_ignored();
        test_seq("start_ignored", 0, 0, 1, seq_rggb);
    endtask

    task automatic test_reset_midframe();
        int acc;
        acc = 0;
        @(negedge clk);
        pattern = 2'd0;
        start   = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && acc < 5; k++) begin
            red = P'(100 + acc); green = P'(200 + acc); blue = P'(300 + acc);
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
        end
        n_tests++;
        if (acc != 5) begin
            n_fail++;
            $display("FAIL reset_mid_accepts: got %0d expected 5", acc);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        n_tests++;
        if ({in_ready, out_valid, out_sof, out_eol, out_eof, busy, done} !== 7'b0 || cfa_pixel !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got rdy/vld/sof/eol/eof/busy/done=%07b pix=%0d expected all 0",
                     {in_ready, out_valid, out_sof, out_eol, out_eof, busy, done}, cfa_pixel);
        end
        @(negedge clk);
        rst = 1'b0;
        test_seq("after_reset", 0, 0, 0, seq_rggb);
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(0, 3)), 2, 1, 0,
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
    endtask

`ifdef CFA_MOSAIC_WB_EN
    task automatic test_wb();
        int want[3] = '{4095, 4000, 2000};
        int idx[3]  = '{0, 1, 5};
        run_frame(0, 0, 2, 0, 192, 64);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (idx[i] >= got.size() || got[idx[i]] != want[i]) begin
                n_fail++;
                $display("FAIL wb_beat%0d: got %0d expected %0d", idx[i],
                         (idx[i] < got.size()) ? got[idx[i]] : -1, want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_pattern3();
        test_backpressure();
        test_start_ignored();
        test_reset_midframe();
        test_random();
`ifdef CFA_MOSAIC_WB_EN
        test_wb();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
